asmd_mult_feeder: RTL and testbench
===================================

Name: asmd_mult_feeder

Overview:
Operand-issue stage directly upstream of asmd_multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one multiplication at a time through the multiplier's start/ready handshake.
- Captures each product and presents it on a valid/ready result stream, so the multi-cycle sequential multiplier can be used by streaming logic.

Parameters:
- word_length, 4, operand width (matches asmd_multiplier word_length)
- fifo_depth, 4, operand FIFO entries; power of two, >= 2

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state)
- in_valid  input  1  operand pair offered
- in_ready  output  1  FIFO can accept; equals !fifo_full
- in_a  input  word_length  multiplicand
- in_b  input  word_length  multiplier operand
- word0  output  word_length  to asmd_multiplier word0
- word1  output  word_length  to asmd_multiplier word1
- start  output  1  to asmd_multiplier start, one-cycle pulse
- mult_product  input  2*word_length  from asmd_multiplier product
- mult_ready  input  1  from asmd_multiplier ready (high = idle/done)
- out_valid  output  1  result held
- out_ready  input  1  downstream accepts result
- out_product  output  2*word_length  registered product
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (async, reset low): FIFO empty; pointers 0; state IDLE; start=0; word0=word1=0; out_valid=0; out_product=0; busy=0. in_ready is 1 once reset deasserts.
- Multiplier contract:
  - start is sampled when mult_ready=1.
  - mult_ready falls within 1-2 cycles after start.
  - mult_ready rises when mult_product is valid.
  - mult_product is stable while mult_ready=1.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop occurs only in ISSUE.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push while full never happens because in_ready=0.
  - Pointers wrap modulo fifo_depth.
  - Full/empty are tracked with a count of width clog2(fifo_depth)+1.
- State machine (registered outputs):
  - IDLE: go to ISSUE when fifo nonempty && mult_ready && !out_valid.
  - ISSUE: start=1 for exactly this cycle; word0/word1 load the FIFO head on entry and hold until the next ISSUE; pop head; go to WAIT_BUSY.
  - WAIT_BUSY: start=0; go to WAIT_DONE when mult_ready=0. If mult_ready is still 1 after 2 cycles in WAIT_BUSY, return to ISSUE with the same operands (re-pulse start, no second pop).
  - WAIT_DONE: when mult_ready=1, out_product<=mult_product, out_valid<=1, go to IDLE.
- Result:
  - out_valid clears on the cycle after out_valid && out_ready.
  - out_product holds until the next capture.
  - A new operation cannot be issued while out_valid=1, so exactly one result is outstanding.
- Latency: at most 1 cycle from push into an empty FIFO to start (registered IDLE->ISSUE transition), plus the multiplier's compute time plus 1 capture cycle.
- Width: out_product is exactly 2*word_length. No truncation or sign handling; operands are unsigned.
- Reset mid-operation: start drops immediately and buffered operands are discarded. The multiplier is reset by the same system reset.
- Simultaneous out_ready with capture cannot occur, because out_valid=0 while in WAIT_DONE.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the default word_length.
- One natural sub-module: operand_fifo (parameterised sync FIFO, width 2*word_length, depth fifo_depth, async active-low reset).
- The FSM and result register live in the top level.

Test Plan:
- Reset asserted low mid-stream (after start) -> start=0, out_valid=0, in_ready=1, FIFO empty on release; no stale result later.
- Single op: in_a=4'b1000, in_b=4'b1111 pushed -> one start pulse, word0=8, word1=15; after mult_ready rises, out_valid=1, out_product=8'd120; holds until out_ready.
- Back-to-back: push (3,5),(15,15),(0,9),(7,1) with out_ready=1 -> results 15, 225, 0, 7 in order; exactly 4 start pulses.
- Full FIFO: push 4 pairs while out_ready=0 and first result pending -> in_ready=0 after 4th accepted; 5th offer stalls; no lost or duplicated ops after out_ready released.
- Backpressure: out_ready=0 for 20 cycles with queued ops -> no start issued while out_valid=1; out_product stable.
- Boundary operands: (0,0)->0, (15,15)->225, (1,15)->15; FIFO pointers wrap correctly across 10 consecutive ops.

Source files
------------

// File: rtl/asmd_mult_feeder_pkg.sv
// Shared definitions for the asmd_multiplier operand feeder: FSM state
// encodings and default sizing.
package asmd_mult_feeder_pkg;

    localparam int DEFAULT_WORD_LENGTH = 4;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    // Cycles spent in WAIT_BUSY with mult_ready still high before re-pulsing start.
    localparam int RETRY_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/asmd_mult_feeder_operand_fifo.sv
// Synchronous FIFO holding packed operand pairs; full/empty derived from an
// occupancy count one bit wider than the pointers.
module asmd_mult_feeder_operand_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push_fire;
    logic pop_fire;

    assign full      = (count_q == CW'(depth));
    assign empty     = (count_q == '0);
    assign push_fire = push && !full;
    assign pop_fire  = pop && !empty;
    assign head_data = mem[rd_ptr_q];

    // Pointers are exactly log2(depth) bits wide, so increments wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/asmd_mult_feeder.sv
// Streams operand pairs into a start/ready sequential multiplier one at a time
// and hands each product downstream on a valid/ready result port.
module asmd_mult_feeder
    import asmd_mult_feeder_pkg::*;
#(
    parameter int word_length = DEFAULT_WORD_LENGTH,
    parameter int fifo_depth  = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [word_length-1:0]   in_a,
    input  logic [word_length-1:0]   in_b,
    output logic [word_length-1:0]   word0,
    output logic [word_length-1:0]   word1,
    output logic                     start,
    input  logic [2*word_length-1:0] mult_product,
    input  logic                     mult_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*word_length-1:0] out_product,
    output logic                     busy
);

    localparam int PW = 2 * word_length;

    state_t state_q, state_d;

    logic                   start_q,       start_d;
    logic [word_length-1:0] word0_q,       word0_d;
    logic [word_length-1:0] word1_q,       word1_d;
    logic                   out_valid_q,   out_valid_d;
    logic [PW-1:0]          out_product_q, out_product_d;
    logic                   wait_cnt_q,    wait_cnt_d;
    logic                   reissue_q,     reissue_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW-1:0] fifo_head;

    asmd_mult_feeder_operand_fifo #(
        .width (PW),
        .depth (fifo_depth)
    ) u_operand_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        word0_d       = word0_q;
        word1_d       = word1_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        wait_cnt_d    = wait_cnt_q;
        reissue_d     = reissue_q;
        fifo_pop      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Holding off while a result is pending keeps exactly one result outstanding.
                if (!fifo_empty && mult_ready && !out_valid_q) begin
                    state_d   = ISSUE;
                    start_d   = 1'b1;
                    word0_d   = fifo_head[PW-1:word_length];
                    word1_d   = fifo_head[word_length-1:0];
                    reissue_d = 1'b0;
                end
            end
            ISSUE: begin
                fifo_pop   = !reissue_q;
                wait_cnt_d = 1'b0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!mult_ready) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt_q == 1'(RETRY_CYCLES - 1)) begin
                    // Multiplier never acknowledged: re-pulse with the same held operands.
                    state_d   = ISSUE;
                    start_d   = 1'b1;
                    reissue_d = 1'b1;
                end else begin
                    wait_cnt_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (mult_ready) begin
                    out_product_d = mult_product;
                    out_valid_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            word0_q       <= '0;
            word1_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            wait_cnt_q    <= 1'b0;
            reissue_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            word0_q       <= word0_d;
            word1_q       <= word1_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            wait_cnt_q    <= wait_cnt_d;
            reissue_q     <= reissue_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign start       = start_q;
    assign word0       = word0_q;
    assign word1       = word1_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_asmd_mult_feeder.sv
// Self-checking bench for asmd_mult_feeder with a behavioural start/ready
// multiplier and an in-order scoreboard of pushed operand pairs.
module tb_asmd_mult_feeder;

    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [W-1:0]   word0;
    logic [W-1:0]   word1;
    logic           start;
    logic [2*W-1:0] mult_product;
    logic           mult_ready;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;
    logic           busy;

    asmd_mult_feeder #(
        .word_length (W),
        .fifo_depth  (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .word0        (word0),
        .word1        (word1),
        .start        (start),
        .mult_product (mult_product),
        .mult_ready   (mult_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: random compute time, can be told to ignore a start.
    logic [2*W-1:0] m_pend;
    int             m_cnt;
    int             acc_cnt;
    int             drop_req  = 0;
    int             drop_done = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_ready   <= 1'b1;
            mult_product <= '0;
            m_pend       <= '0;
            m_cnt        <= 0;
            acc_cnt      <= 0;
        end else if (mult_ready && start) begin
            if (drop_done < drop_req) begin
                drop_done <= drop_done + 1;
            end else begin
                mult_ready <= 1'b0;
                m_cnt      <= int'($urandom_range(0, 4));
                m_pend     <= 8'(word0) * 8'(word1);
                acc_cnt    <= acc_cnt + 1;
            end
        end else if (!mult_ready) begin
            if (m_cnt == 0) begin
                mult_ready   <= 1'b1;
                mult_product <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int exp_a[$];
    int exp_b[$];
    int res_idx   = 0;
    int start_cnt = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input int a, input int b);
        bit ok;
        ok       = 1'b0;
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (res_idx == exp_a.size() && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("drain_timeout", res_idx, exp_a.size());
    endtask

    task automatic monitor();
        bit prev_start;
        int p;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_a.delete();
                exp_b.delete();
                res_idx    = 0;
                prev_start = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    exp_a.push_back(int'(in_a));
                    exp_b.push_back(int'(in_b));
                end
                if (start) begin
                    start_cnt++;
                    check("start_single_cycle", 64'(prev_start), 0);
                    check("start_while_result", 64'(out_valid), 0);
                    if (acc_cnt < exp_a.size()) begin
                        check("issue_word0", 64'(word0), 64'(exp_a[acc_cnt]));
                        check("issue_word1", 64'(word1), 64'(exp_b[acc_cnt]));
                    end else begin
                        fail("issue_without_operands", acc_cnt, exp_a.size());
                    end
                end
                if (out_valid && out_ready) begin
                    if (res_idx < exp_a.size()) begin
                        p = exp_a[res_idx] * exp_b[res_idx];
                        $display("result %0d: %0d * %0d -> %0d (expect %0d)",
                                 res_idx, exp_a[res_idx], exp_b[res_idx], out_product, p);
                        check("result_product", 64'(out_product), 64'(p));
                    end else begin
                        fail("unexpected_result", res_idx, exp_a.size());
                    end
                    res_idx++;
                end
                prev_start = start;
            end
        end
    endtask

    initial begin
        int s0;
        int r0;
        int viol;
        bit seen;
        logic [2*W-1:0] held;

        vecs[0] = '{a: 4'd8,  b: 4'd15, p: 8'd120};
        vecs[1] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
        vecs[2] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        vecs[4] = '{a: 4'd7,  b: 4'd1,  p: 8'd7};
        vecs[5] = '{a: 4'd0,  b: 4'd0,  p: 8'd0};
        vecs[6] = '{a: 4'd1,  b: 4'd15, p: 8'd15};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start", 64'(start), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_product", 64'(out_product), 0);
        check("rst_word0", 64'(word0), 0);
        check("rst_word1", 64'(word1), 0);
        check("rst_busy", 64'(busy), 0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 1);
        sync();

        // Single operations from the vector table, result held under backpressure
        foreach (vecs[i]) begin
            out_ready = 1'b0;
            s0 = start_cnt;
            push(int'(vecs[i].a), int'(vecs[i].b));
            @(negedge clk);
            check("vec_no_early_start", 64'(start), 0);
            @(negedge clk);
            check("vec_start_latency", 64'(start), 1);
            wait_out_valid(40);
            check("vec_product", 64'(out_product), 64'(vecs[i].p));
            repeat (5) @(negedge clk);
            check("vec_hold_valid", 64'(out_valid), 1);
            check("vec_hold_product", 64'(out_product), 64'(vecs[i].p));
            check("vec_start_count", 64'(start_cnt - s0), 1);
            sync();
            out_ready = 1'b1;
            sync();
            out_ready = 1'b0;
            @(negedge clk);
            check("vec_valid_clear", 64'(out_valid), 0);
            sync();
        end

        // Back-to-back stream with the result port always ready
        out_ready = 1'b1;
        s0 = start_cnt;
        r0 = res_idx;
        push(3, 5);
        push(15, 15);
        push(0, 9);
        push(7, 1);
        wait_drain(200);
        check("b2b_starts", 64'(start_cnt - s0), 4);
        check("b2b_results", 64'(res_idx - r0), 4);
        sync();

        // Fill the FIFO behind a pending result, then hold backpressure
        out_ready = 1'b0;
        r0 = res_idx;
        push(2, 3);
        wait_out_valid(40);
        sync();
        push(4, 4);
        push(5, 3);
        push(6, 2);
        push(9, 9);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 0);
        sync();
        held = out_product;
        s0 = start_cnt;
        viol = 0;
        in_a = 4'd11;
        in_b = 4'd13;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (in_ready || start || !out_valid || out_product !== held) viol++;
        end
        check("backpressure_violations", 64'(viol), 0);
        check("backpressure_starts", 64'(start_cnt - s0), 0);
        check("backpressure_product", 64'(out_product), 8'd6);
        sync();
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail("fifth_push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain(300);
        check("full_results", 64'(res_idx - r0), 6);
        sync();

        // Multiplier ignores the first start: same operands re-issued, one pop
        drop_req++;
        s0 = start_cnt;
        r0 = res_idx;
        push(9, 7);
        push(12, 10);
        wait_drain(200);
        check("retry_starts", 64'(start_cnt - s0), 3);
        check("retry_results", 64'(res_idx - r0), 2);
        sync();

        // Randomized stream with random result backpressure and two ignored starts
        drop_req += 2;
        r0 = res_idx;
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    push(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) sync();
                end
            end
            begin
                repeat (250) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(400);
        check("random_results", 64'(res_idx - r0), 14);
        sync();

        // Reset in the middle of an operation
        out_ready = 1'b0;
        push(5, 6);
        push(7, 8);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail("midreset_no_start", 0, 1);
        reset = 1'b0;
        #1;
        check("midreset_start", 64'(start), 0);
        check("midreset_out_valid", 64'(out_valid), 0);
        check("midreset_busy", 64'(busy), 0);
        check("midreset_word0", 64'(word0), 0);
        check("midreset_in_ready", 64'(in_ready), 1);
        repeat (2) @(negedge clk);
        sync();
        reset = 1'b1;
        out_ready = 1'b1;
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || start || busy) viol++;
        end
        check("midreset_no_stale", 64'(viol), 0);
        sync();
        push(3, 3);
        wait_drain(100);
        check("midreset_fresh_results", 64'(res_idx), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
